// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions: FSM states, default widths and ctrl bundle bit offsets.
package pipe_stage_skid_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Bit positions of the named fields inside the ctrl bundle.
  typedef enum int {
    CTRL_REGWR    = 0,
    CTRL_MEM2REG  = 1,
    CTRL_LINK     = 2,
    CTRL_OVERFLOW = 3,
    CTRL_RW       = 4
  } ctrl_field_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between a pipeline stage and its neighbours.
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// One {valid, ctrl, data} pipeline register with load and independent ctrl/data clears.
module pipe_entry_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clearing ctrl also drops valid so an empty slot never exposes stale ctrl bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else begin
      if (clear_ctrl) begin
        valid <= 1'b0;
        ctrl  <= '0;
      end else if (load) begin
        valid <= 1'b1;
        ctrl  <= load_ctrl;
      end
      if (clear_data) begin
        data <= '0;
      end else if (load) begin
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a head register and one skid register, fully registered outputs.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int FLUSH_ALL = 0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_skid_if.slave     bus,
  output logic [CNT_W-1:0]     stall_cnt
);

  stage_state_t      state, state_next;
  logic              ready;
  logic              accept, pop;
  logic              head_load, head_from_skid, head_clear;
  logic              skid_load, skid_clear, data_clear;
  logic              head_valid, skid_valid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_load_ctrl;
  logic [DATA_W-1:0] head_data, skid_data, head_load_data;

  assign accept = bus.in_valid & ready;
  assign pop    = head_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      ready <= 1'b1;
    end else begin
      state <= state_next;
      ready <= (state_next != FULL);
    end
  end

  always_comb begin
    state_next     = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    head_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    data_clear     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
      data_clear = (FLUSH_ALL != 0);
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_load  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (pop) begin
            head_clear = 1'b1;
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop && skid_valid) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  assign head_load_ctrl = head_from_skid ? skid_ctrl : bus.in_ctrl;
  assign head_load_data = head_from_skid ? skid_data : bus.in_data;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) head_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (head_load),
    .clear_ctrl (head_clear),
    .clear_data (data_clear),
    .load_ctrl  (head_load_ctrl),
    .load_data  (head_load_data),
    .valid      (head_valid),
    .ctrl       (head_ctrl),
    .data       (head_data)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skid_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .clear_ctrl (skid_clear),
    .clear_data (data_clear),
    .load_ctrl  (bus.in_ctrl),
    .load_data  (bus.in_data),
    .valid      (skid_valid),
    .ctrl       (skid_ctrl),
    .data       (skid_data)
  );

  // Counts downstream backpressure; survives flush, only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (head_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = head_valid;
  assign bus.out_ctrl  = head_ctrl;
  assign bus.out_data  = head_data;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, 32, width of the datapath payload (ALU result, memory data, PC).
REQ-002 Parameter CTRL_W, 8, width of the control-signal bundle (regWr, mem2Reg, link, overflow, rw, ...).
REQ-003 Parameter FLUSH_ALL, 0, 0 = flush zeroes control fields only; 1 = flush zeroes control and data.
REQ-004 Parameter CNT_W, 16, width of the stall performance counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous kill of all held entries (branch/jump taken).
REQ-008 in_valid  input  1  upstream stage presents an entry.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 out_valid  output  1  the head entry is valid.
REQ-013 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-014 out_ctrl  output  CTRL_W  head control bundle; all-zero whenever out_valid=0.
REQ-015 out_data  output  DATA_W  head payload.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Storage: one head register and one skid register, each holding {valid, ctrl, data}; all outputs are driven directly from registers.
REQ-018 FSM states: EMPTY (no valid entry), ONE (head valid), FULL (head and skid valid).
REQ-019 Handshake: accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 in_ready = 1 in EMPTY and ONE, and 0 in FULL; in_ready is registered with no combinational path from out_ready.
REQ-021 Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept & ~pop -> FULL.
  - ONE + pop & ~accept -> EMPTY.
  - ONE + accept & pop -> ONE (head replaced).
  - FULL + pop -> ONE (skid moves to head).
REQ-022 Latency: an accepted entry appears on out_* exactly one cycle after acceptance when the stage was EMPTY, or when it was ONE with pop.
REQ-023 Ordering is strictly FIFO; no entry is duplicated or lost except by flush.
REQ-024 Flush has priority over accept and pop; next state is EMPTY, both valids clear, and both ctrl fields are zeroed.
REQ-025 Data on flush: data fields are held when FLUSH_ALL=0 and zeroed when FLUSH_ALL=1.
REQ-026 Flush in the same cycle as in_valid drops the incoming entry; in_ready reads 1 in the cycle after flush.
REQ-027 Hold: in ONE and FULL with ~pop & ~flush, the head ctrl and data stay bit-stable.
REQ-028 stall_cnt increments by 1 per stalled cycle, saturates at 2^CNT_W-1, and is not cleared by flush.

Reset
REQ-029 With reset=1 at a rising edge: state=EMPTY, all valids=0, all ctrl and data=0, stall_cnt=0, in_ready=1 from the next cycle.
REQ-030 Reset has priority over flush, accept and pop; entries present mid-operation are discarded.

Structure
REQ-031 A shared pipeline package holds the FSM state enumeration (EMPTY/ONE/FULL), the default widths, and the ctrl bundle field offsets used by all stage instances.
REQ-032 One sub-module is natural: pipe_entry_reg (a single {valid, ctrl, data} register with load, clear-ctrl and clear-data controls), instantiated for head and skid.

Verification
REQ-033 Steady stream: in_valid=1 and out_ready=1 for 10 cycles with data 0..9 -> out_data 0..9 on consecutive cycles starting one cycle late; state is never FULL.
REQ-034 Backpressure: out_ready=0 while entries 0xA and 0xB are sent -> FULL, in_ready=0, out_data=0xA held; release out_ready -> 0xA then 0xB delivered; stall_cnt equals the number of stalled cycles.
REQ-035 Flush in FULL with in_valid=1 (data 0xC) -> next cycle out_valid=0, out_ctrl=0, 0xC never emitted, in_ready=1.
REQ-036 FLUSH_ALL=1 vs 0: flush while holding data 0xDEADBEEF -> out_data=0 for FLUSH_ALL=1, and 0xDEADBEEF with out_valid=0 for FLUSH_ALL=0.
REQ-037 Reset asserted in FULL together with flush and out_ready -> all outputs 0 and stall_cnt=0 the next cycle; CNT_W=4 with 20 stalled cycles -> stall_cnt=15.
